// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types for the FIFO read-side output slice.
//
// Contents:
//   slice_state_t : occupancy of the 2-entry elastic output buffer.
//                   The encoding equals the number of buffered beats
//                   (EMPTY=0, ONE=1, FULL=2). The optional level output
//                   relies on this.
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

endpackage : fifo_pkg

// File: rtl/fifo_read_slice_reg.sv
// -----------------------------------------------------------------------------
// fifo_read_slice_reg
// C_DATA_WIDTH-wide register with a load enable. It is used for the output
// entry and the skid entry of fifo_read_slice. It has no reset because the
// stored data is only meaningful while the matching valid state is set.
//
// Parameters:
//   C_DATA_WIDTH : data width in bits
//
// Ports:
//   clk   in   clock
//   load  in   capture d on the next rising edge
//   d     in   C_DATA_WIDTH  data to capture
//   q     out  C_DATA_WIDTH  stored data
// -----------------------------------------------------------------------------
module fifo_read_slice_reg #(
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic [C_DATA_WIDTH-1:0] d,
    output logic [C_DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule : fifo_read_slice_reg

// File: rtl/fifo_read_slice.sv
// -----------------------------------------------------------------------------
// fifo_read_slice
// 2-entry elastic output buffer placed between the FIFO read port (the gray
// address stage) and an AXI-Stream master interface. All outputs come
// straight from flops, so m_axis_ready has no combinational path to
// fifo_ready. Full throughput is one beat per cycle.
//
// Parameters:
//   C_DATA_WIDTH : data path width in bits (default 64)
//
// Ports:
//   m_axis_aclk    in   clock for all logic
//   m_axis_areset  in   asynchronous active-high reset
//   fifo_valid     in   read-side valid from the gray address stage
//   fifo_ready     out  pop qualifier to the gray address stage
//   fifo_data      in   C_DATA_WIDTH  RAM read data
//   m_axis_valid   out  AXI-Stream valid
//   m_axis_ready   in   AXI-Stream ready
//   m_axis_data    out  C_DATA_WIDTH  AXI-Stream data
//   m_axis_level   out  2  number of buffered beats (0/1/2). This port only
//                         exists when FIFO_READ_SLICE_LEVEL_EN is defined.
//
// Configuration macro: FIFO_READ_SLICE_LEVEL_EN
// -----------------------------------------------------------------------------
module fifo_read_slice
    import fifo_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                    m_axis_aclk,
    input  logic                    m_axis_areset,
    input  logic                    fifo_valid,
    output logic                    fifo_ready,
    input  logic [C_DATA_WIDTH-1:0] fifo_data,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [C_DATA_WIDTH-1:0] m_axis_data
`ifdef FIFO_READ_SLICE_LEVEL_EN
    ,
    output logic [1:0]              m_axis_level
`endif
);

    slice_state_t            state;
    slice_state_t            state_next;
    logic                    valid_q;
    logic                    valid_next;
    logic                    ready_q;
    logic                    ready_next;
    logic                    up_xfer;
    logic                    down_xfer;
    logic                    out_load;
    logic                    out_sel_skid;
    logic                    skid_load;
    logic [C_DATA_WIDTH-1:0] out_d;
    logic [C_DATA_WIDTH-1:0] skid_q;

    assign up_xfer   = fifo_valid && ready_q;
    assign down_xfer = valid_q && m_axis_ready;

    // The output entry always holds the oldest beat. The skid entry is only
    // written when a beat arrives while the output entry is stalled. It is
    // drained back into the output entry on FULL->ONE, which keeps the order.
    always_comb begin
        state_next   = state;
        out_load     = 1'b0;
        out_sel_skid = 1'b0;
        skid_load    = 1'b0;
        case (state)
            EMPTY: begin
                if (up_xfer) begin
                    state_next = ONE;
                    out_load   = 1'b1;
                end
            end
            ONE: begin
                if (up_xfer && !down_xfer) begin
                    state_next = FULL;
                    skid_load  = 1'b1;
                end else if (!up_xfer && down_xfer) begin
                    state_next = EMPTY;
                end else if (up_xfer && down_xfer) begin
                    out_load = 1'b1;
                end
            end
            FULL: begin
                // fifo_ready is low here, so fifo_valid cannot cause a transfer.
                if (down_xfer) begin
                    state_next   = ONE;
                    out_load     = 1'b1;
                    out_sel_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Handshake flags are registered copies of the next-state decode. This
    // keeps both interfaces free of combinational paths.
    always_comb begin
        valid_next = (state_next != EMPTY);
        ready_next = (state_next != FULL);
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            valid_q <= valid_next;
            ready_q <= ready_next;
        end
    end

    assign out_d = out_sel_skid ? skid_q : fifo_data;

    fifo_read_slice_reg #(
        .C_DATA_WIDTH(C_DATA_WIDTH)
    ) u_out_reg (
        .clk  (m_axis_aclk),
        .load (out_load),
        .d    (out_d),
        .q    (m_axis_data)
    );

    fifo_read_slice_reg #(
        .C_DATA_WIDTH(C_DATA_WIDTH)
    ) u_skid_reg (
        .clk  (m_axis_aclk),
        .load (skid_load),
        .d    (fifo_data),
        .q    (skid_q)
    );

    assign m_axis_valid = valid_q;
    assign fifo_ready   = ready_q;

`ifdef FIFO_READ_SLICE_LEVEL_EN
    assign m_axis_level = state;
`endif

endmodule : fifo_read_slice

// File: tb/tb_fifo_read_slice.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_slice
// Self-checking bench for fifo_read_slice (C_DATA_WIDTH = 64). It runs
// directed sequences with hand-computed expectations, then a random
// valid/ready stream that is checked against a queue-and-level reference.
// Define FIFO_READ_SLICE_LEVEL_EN to also check m_axis_level.
// -----------------------------------------------------------------------------
module tb_fifo_read_slice;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         fifo_valid;
    logic         fifo_ready;
    logic [W-1:0] fifo_data;
    logic         m_axis_valid;
    logic         m_axis_ready;
    logic [W-1:0] m_axis_data;
`ifdef FIFO_READ_SLICE_LEVEL_EN
    logic [1:0]   m_axis_level;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_read_slice #(
        .C_DATA_WIDTH(W)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .fifo_valid    (fifo_valid),
        .fifo_ready    (fifo_ready),
        .fifo_data     (fifo_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_data   (m_axis_data)
`ifdef FIFO_READ_SLICE_LEVEL_EN
        ,
        .m_axis_level  (m_axis_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r);
        fifo_valid   = v;
        fifo_data    = d;
        m_axis_ready = r;
    endtask

    // Waits for the next active edge, then lets the registers settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] sb[$];
        int           lvl;
        int           popped;
        int           cycles;
        logic         v;
        logic         r;
        logic [W-1:0] d;
        bit           up;
        bit           down;

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("rst_valid", m_axis_valid, 0);
        checkOutput("rst_ready", fifo_ready, 1);
`ifdef FIFO_READ_SLICE_LEVEL_EN
        checkOutput("rst_level", m_axis_level, 0);
`endif
        step();
        step();
        rst = 1'b0;

        // Single beat: one-cycle latency
        applyStimulus(1'b1, 64'hA1, 1'b1);
        checkOutput("a1_pre_valid", m_axis_valid, 0);
        step();
        checkOutput("a1_valid", m_axis_valid, 1);
        checkOutput("a1_data", m_axis_data, 64'hA1);
        checkOutput("a1_ready", fifo_ready, 1);
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("a1_drain_valid", m_axis_valid, 0);

        // Back-to-back stream 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, W'(i), 1'b1);
            step();
            checkOutput("stream_valid", m_axis_valid, 1);
            checkOutput("stream_data", m_axis_data, 64'(i));
            checkOutput("stream_ready", fifo_ready, 1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("stream_end_valid", m_axis_valid, 0);

        // Stall until full, then drain
`ifdef FIFO_READ_SLICE_LEVEL_EN
        checkOutput("lvl_seq0", m_axis_level, 0);
`endif
        applyStimulus(1'b1, 64'h11, 1'b0);
        step();
        checkOutput("stall1_valid", m_axis_valid, 1);
        checkOutput("stall1_data", m_axis_data, 64'h11);
        checkOutput("stall1_ready", fifo_ready, 1);
`ifdef FIFO_READ_SLICE_LEVEL_EN
        checkOutput("lvl_seq1", m_axis_level, 1);
`endif
        applyStimulus(1'b1, 64'h22, 1'b0);
        step();
        checkOutput("full_ready", fifo_ready, 0);
        checkOutput("full_valid", m_axis_valid, 1);
        checkOutput("full_data", m_axis_data, 64'h11);
`ifdef FIFO_READ_SLICE_LEVEL_EN
        checkOutput("lvl_seq2", m_axis_level, 2);
`endif
        applyStimulus(1'b1, 64'h33, 1'b0);
        step();
        checkOutput("full_hold_ready", fifo_ready, 0);
        checkOutput("full_hold_data", m_axis_data, 64'h11);
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("drain1_valid", m_axis_valid, 1);
        checkOutput("drain1_data", m_axis_data, 64'h22);
        checkOutput("drain1_ready", fifo_ready, 1);
`ifdef FIFO_READ_SLICE_LEVEL_EN
        checkOutput("lvl_seq3", m_axis_level, 1);
`endif
        step();
        checkOutput("drain2_valid", m_axis_valid, 0);
`ifdef FIFO_READ_SLICE_LEVEL_EN
        checkOutput("lvl_seq4", m_axis_level, 0);
`endif

        // Asynchronous reset while full
        applyStimulus(1'b1, 64'h66, 1'b0);
        step();
        applyStimulus(1'b1, 64'h77, 1'b0);
        step();
        checkOutput("prerst_full_ready", fifo_ready, 0);
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", m_axis_valid, 0);
        checkOutput("async_rst_ready", fifo_ready, 1);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 64'h55, 1'b1);
        step();
        checkOutput("post_rst_valid", m_axis_valid, 1);
        checkOutput("post_rst_data", m_axis_data, 64'h55);
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("post_rst_empty", m_axis_valid, 0);

        // Random valid/ready with a reference queue
        lvl    = 0;
        popped = 0;
        cycles = 0;
        while (popped < 10000 && cycles < 60000) begin
            checkOutput("rnd_ready", fifo_ready, 64'(lvl != 2));
            checkOutput("rnd_valid", m_axis_valid, 64'(lvl != 0));
            if (lvl != 0) begin
                checkOutput("rnd_data", m_axis_data, sb[0]);
            end
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            applyStimulus(v, d, r);
            up   = v && (lvl != 2);
            down = r && (lvl != 0);
            if (down) begin
                void'(sb.pop_front());
                popped++;
            end
            if (up) begin
                sb.push_back(d);
            end
            lvl = lvl + int'(up) - int'(down);
            step();
            cycles++;
        end
        if (popped < 10000) begin
            checkOutput("rnd_timeout", 64'(popped), 64'd10000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_read_slice

// File: doc/fifo_read_slice.md
FIFO_READ_SLICE -- requirements
Module: fifo_read_slice

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 64, width of the data path in bits.
REQ-002 SHALL have port m_axis_aclk  input  1  single clock for all logic.
REQ-003 SHALL have port m_axis_areset  input  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have port fifo_valid  input  1  upstream read-side valid, driven by the gray address stage m_axis_valid.
REQ-005 SHALL have port fifo_ready  output  1  pop strobe qualifier, drives the gray address stage m_axis_ready.
REQ-006 SHALL have port fifo_data  input  C_DATA_WIDTH  RAM read data, valid in any cycle where fifo_valid=1.
REQ-007 SHALL have port m_axis_valid  output  1  downstream AXI-Stream valid.
REQ-008 SHALL have port m_axis_ready  input  1  downstream AXI-Stream ready.
REQ-009 SHALL have port m_axis_data  output  C_DATA_WIDTH  downstream AXI-Stream data.

Function
REQ-010 SHALL implement a 2-entry elastic output buffer with states EMPTY, ONE, FULL.
REQ-011 SHALL define upstream transfer as fifo_valid&&fifo_ready and downstream transfer as m_axis_valid&&m_axis_ready.
REQ-012 SHALL drive fifo_ready from a register only: 1 in EMPTY and ONE, 0 in FULL, no combinational path from m_axis_ready.
REQ-013 SHALL drive m_axis_valid and m_axis_data from registers only: m_axis_valid=1 in ONE and FULL.
REQ-014 Transitions: EMPTY->ONE on upstream transfer; ONE->FULL on upstream without downstream; ONE->EMPTY on downstream without upstream; ONE->ONE on both; FULL->ONE on downstream.
REQ-015 In FULL, upstream transfer is impossible; fifo_valid SHALL be ignored.
REQ-016 On simultaneous transfers in ONE, new fifo_data SHALL load the output register in that same edge.
REQ-017 On FULL->ONE, the skid entry SHALL move into the output register; data order SHALL be preserved.
REQ-018 Latency from upstream transfer into EMPTY to m_axis_valid=1 SHALL be exactly 1 cycle.
REQ-019 Sustained throughput SHALL be one beat per cycle while fifo_valid=1 and m_axis_ready=1.
REQ-020 m_axis_data SHALL remain stable while m_axis_valid=1 and m_axis_ready=0 (AXI-Stream rule).
REQ-021 fifo_data SHALL be sampled only on an upstream transfer edge.

Reset
REQ-022 On m_axis_areset=1, state SHALL go to EMPTY immediately without clock.
REQ-023 Reset values: m_axis_valid=0, fifo_ready=1, level=0; data registers are don't-care and need no reset.
REQ-024 Reset mid-transfer SHALL discard both buffered entries; first beat after release SHALL be the next upstream beat.
REQ-025 fifo_ready SHALL stay 1 during reset; the upstream stage owns its own reset.

Configuration
REQ-026 With macro FIFO_READ_SLICE_LEVEL_EN defined: extra output m_axis_level  output  2  buffered beats (0/1/2), registered, equal to state encoding.
REQ-027 Without FIFO_READ_SLICE_LEVEL_EN: port m_axis_level SHALL be absent; all other behaviour is identical.

Structure
REQ-028 State encoding (EMPTY=0, ONE=1, FULL=2) SHALL live in shared package fifo_pkg as a typedef; no other constants are needed.
REQ-029 One sub-module, fifo_read_slice_reg (C_DATA_WIDTH-wide enable-load register), SHALL be instantiated twice (output and skid entries).

Verification
REQ-030 Reset, then fifo_valid=1 data=0xA1, m_axis_ready=1 -> m_axis_valid=1 data=0xA1 one cycle later, fifo_ready stays 1.
REQ-031 Stream 0x01..0x10 with m_axis_ready=1 -> 16 beats on 16 consecutive cycles, in order.
REQ-032 m_axis_ready=0, push 0x11,0x22 -> FULL, fifo_ready=0, data held 0x11; raise ready -> 0x11 then 0x22.
REQ-033 Random fifo_valid/m_axis_ready 50% for 10000 beats -> scoreboard exact order, no loss or duplicate, stable data while stalled.
REQ-034 Assert m_axis_areset in FULL -> m_axis_valid=0 and fifo_ready=1 before next edge; next beat 0x55 emerges first.
REQ-035 With FIFO_READ_SLICE_LEVEL_EN, REQ-032 sequence -> m_axis_level 0,1,2,1,0.
